tff_counter: RTL and testbench

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_pkg.sv | 18 +
 rtl/tff_cell.sv | 18 +
 rtl/tff_counter.sv | 99 +++++++++
 tb/tb_tff_counter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared constants and types for the toggle-flop based modulo up/down counter.
package tff_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int     TFF_WIDTH_DEFAULT = 4;
    localparam longint TFF_MOD_DEFAULT   = 16;

    // What the counter does on the coming edge, reset aside.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_LOAD = 2'd1,
        STEP_INC  = 2'd2,
        STEP_DEC  = 2'd3
    } step_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on a rising clk edge when t=1, synchronous
// active-high reset to 0. Holds no count logic of its own.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// Modulo-MOD up/down counter with clamped parallel load, built from one
// toggle cell per bit. Define TFF_COUNTER_SAT_EN to saturate instead of wrap.
module tff_counter
    import tff_pkg::*;
#(
    parameter int     WIDTH = TFF_WIDTH_DEFAULT,
    parameter longint MOD   = TFF_MOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

`ifdef TFF_COUNTER_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    step_e            step;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic             wrap_next;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

    // The modulus never exceeds 2**WIDTH, so "load_val >= MOD" is the same
    // as "load_val > MOD-1" and needs no wider comparison.
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    always_comb begin
        step = STEP_HOLD;
        if (load) begin
            step = STEP_LOAD;
        end else if (en) begin
            step = (up == DIR_UP) ? STEP_INC : STEP_DEC;
        end
    end

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        case (step)
            STEP_LOAD: q_next = load_clamped;
            STEP_INC: begin
                if (at_max) begin
                    q_next    = SAT ? MAX_Q : '0;
                    wrap_next = ~SAT;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end
            STEP_DEC: begin
                if (at_zero) begin
                    q_next    = SAT ? '0 : MAX_Q;
                    wrap_next = ~SAT;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
            default: q_next = q;
        endcase
    end

    // A bit's cell toggles only when that bit actually changes.
    assign t = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

    assign tc = (up == DIR_UP) ? at_max : at_zero;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench: vector table on a WIDTH=4/MOD=10 counter, plus a
// WIDTH=3/MOD=8 counter run into its top value (wrap or saturate).
module tb_tff_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap;

    tff_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    logic       rst8, en8, up8, load8;
    logic [2:0] load_val8;
    logic [2:0] q8;
    logic       tc8, wrap8;

    tff_counter #(.WIDTH(3), .MOD(8)) dut8 (
        .clk      (clk),
        .rst      (rst8),
        .en       (en8),
        .up       (up8),
        .load     (load8),
        .load_val (load_val8),
        .q        (q8),
        .tc       (tc8),
        .wrap     (wrap8)
    );

    typedef struct {
        string      name;
        logic       rst, en, up, load;
        logic [3:0] lv;
        logic [3:0] exp_q;
        logic       exp_wrap, exp_tc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(string name, logic r, logic e, logic u, logic l,
                                logic [3:0] lv, logic [3:0] eq, logic ew, logic et);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
        v.exp_q = eq; v.exp_wrap = ew; v.exp_tc = et;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // WIDTH=3/MOD=8 expectations after each of 10 up edges from reset.
    logic [2:0] exp_q8    [10];
    logic       exp_wrap8 [10];

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        rst8 = 1'b1; en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_val8 = '0;

        //   name         rst en up ld lv  q  wr tc
        add("reset",      1, 1, 0, 1, 5,  0, 0, 1);
        add("reset",      1, 1, 0, 1, 5,  0, 0, 1);
        for (int i = 1; i <= 9; i++)
            add("up_cnt",  0, 1, 1, 0, 0, 4'(i), 0, (i == 9));
        add("up_wrap",    0, 1, 1, 0, 0,  0, 1, 0);
        add("up_cnt",     0, 1, 1, 0, 0,  1, 0, 0);
        add("up_cnt",     0, 1, 1, 0, 0,  2, 0, 0);
        add("load0",      0, 0, 0, 1, 0,  0, 0, 1);
        add("dn_wrap",    0, 1, 0, 0, 0,  9, 1, 0);
        add("dn_cnt",     0, 1, 0, 0, 0,  8, 0, 0);
        add("ld_clamp13", 0, 1, 1, 1, 13, 9, 0, 1);
        add("ld_over_wr", 0, 1, 1, 1, 5,  5, 0, 0);
        add("ld_clamp10", 0, 0, 0, 1, 10, 9, 0, 0);
        add("ld_9",       0, 0, 1, 1, 9,  9, 0, 1);
        add("ld_clamp15", 0, 1, 0, 1, 15, 9, 0, 0);
        add("ld_4",       0, 0, 1, 1, 4,  4, 0, 0);
        add("mid_cnt",    0, 1, 1, 0, 0,  5, 0, 0);
        add("mid_cnt",    0, 1, 1, 0, 0,  6, 0, 0);
        add("mid_rst",    1, 1, 1, 0, 0,  0, 0, 0);
        add("hold0",      0, 0, 0, 0, 0,  0, 0, 1);
        add("hold0",      0, 0, 0, 0, 0,  0, 0, 1);
        add("hold0",      0, 0, 0, 0, 0,  0, 0, 1);
        add("resume",     0, 1, 1, 0, 0,  1, 0, 0);
        add("dir_dn",     0, 1, 0, 0, 0,  0, 0, 1);
        add("dir_dn_wr",  0, 1, 0, 0, 0,  9, 1, 0);
        add("dir_up_wr",  0, 1, 1, 0, 0,  0, 1, 0);
        add("dir_up",     0, 1, 1, 0, 0,  1, 0, 0);
        add("hold1",      0, 0, 1, 0, 0,  1, 0, 0);
        add("hold1",      0, 0, 0, 0, 0,  1, 0, 0);

`ifdef TFF_COUNTER_SAT_EN
        exp_q8    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
        exp_wrap8 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_q8    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        exp_wrap8 = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
            load = vecs[i].load; load_val = vecs[i].lv;
            @(posedge clk);
            #1;
            check({vecs[i].name, ".q"},    i, 32'(q),    32'(vecs[i].exp_q));
            check({vecs[i].name, ".wrap"}, i, 32'(wrap), 32'(vecs[i].exp_wrap));
            check({vecs[i].name, ".tc"},   i, 32'(tc),   32'(vecs[i].exp_tc));
        end

        // Second counter: reset, then drive up past MOD-1 = 2**WIDTH-1.
        @(negedge clk);
        rst8 = 1'b1; en8 = 1'b1; load8 = 1'b1; load_val8 = 3'd3;
        @(posedge clk);
        #1;
        check("m8_reset.q", 0, 32'(q8), 0);
        check("m8_reset.wrap", 0, 32'(wrap8), 0);
        @(negedge clk);
        rst8 = 1'b0; load8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("m8_up.q",    i, 32'(q8),    32'(exp_q8[i]));
            check("m8_up.wrap", i, 32'(wrap8), 32'(exp_wrap8[i]));
            check("m8_up.tc",   i, 32'(tc8),   32'(exp_q8[i] == 3'd7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
